// File: rtl/ascon_pack.sv
// Shared ASCON types and constants: 320-bit state, round counts, sequencer states.
package ascon_pack;

   typedef struct packed {
      logic [63:0] x0;
      logic [63:0] x1;
      logic [63:0] x2;
      logic [63:0] x3;
      logic [63:0] x4;
   } type_state;

   localparam int unsigned ROUNDS_A   = 12;
   localparam int unsigned ROUNDS_B   = 6;
   localparam int unsigned MAX_ROUNDS = 12;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } seq_state_e;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

endpackage

// File: rtl/p.sv
// Combinational single ASCON round: constant addition, 5-bit S-box layer, linear diffusion.
module p
   import ascon_pack::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  type_state          pin_i,
   input  logic [CNT_W-1:0]   roundp_i,
   output type_state          pout_o
);

   logic [3:0]  w_r;
   logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
   logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;

   // Round constant for index r of the 12-round schedule is {15-r, r} = {~r, r}.
   assign w_r = 4'(roundp_i);

   always_comb begin
      w_a0 = pin_i.x0;
      w_a1 = pin_i.x1;
      w_a2 = pin_i.x2 ^ {56'd0, ~w_r, w_r};
      w_a3 = pin_i.x3;
      w_a4 = pin_i.x4;

      w_a0 = w_a0 ^ w_a4;
      w_a4 = w_a4 ^ w_a3;
      w_a2 = w_a2 ^ w_a1;
      w_t0 = ~w_a0 & w_a1;
      w_t1 = ~w_a1 & w_a2;
      w_t2 = ~w_a2 & w_a3;
      w_t3 = ~w_a3 & w_a4;
      w_t4 = ~w_a4 & w_a0;
      w_a0 = w_a0 ^ w_t1;
      w_a1 = w_a1 ^ w_t2;
      w_a2 = w_a2 ^ w_t3;
      w_a3 = w_a3 ^ w_t4;
      w_a4 = w_a4 ^ w_t0;
      w_a1 = w_a1 ^ w_a0;
      w_a0 = w_a0 ^ w_a4;
      w_a3 = w_a3 ^ w_a2;
      w_a2 = ~w_a2;

      pout_o.x0 = w_a0 ^ rotr(w_a0, 19) ^ rotr(w_a0, 28);
      pout_o.x1 = w_a1 ^ rotr(w_a1, 61) ^ rotr(w_a1, 39);
      pout_o.x2 = w_a2 ^ rotr(w_a2, 1)  ^ rotr(w_a2, 6);
      pout_o.x3 = w_a3 ^ rotr(w_a3, 10) ^ rotr(w_a3, 17);
      pout_o.x4 = w_a4 ^ rotr(w_a4, 7)  ^ rotr(w_a4, 41);
   end

endmodule

// File: rtl/ascon_perm_seq.sv
// Multi-cycle ASCON permutation: loads a state, applies the last N rounds of the
// 12-round schedule one per clock, then pulses done_o for one cycle.
module ascon_perm_seq
   import ascon_pack::*;
#(
   parameter int unsigned MAX_ROUNDS = 12,
   parameter int unsigned CNT_W      = 4
) (
   input  logic              clock_i,
   input  logic              resetb_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  nrounds_i,
   input  type_state         state_i,
   output type_state         state_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  round_o
);

   localparam logic [CNT_W-1:0] MaxR    = CNT_W'(MAX_ROUNDS);
   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(MAX_ROUNDS - 1);

   seq_state_e       r_fsm;
   type_state        r_state;
   logic [CNT_W-1:0] r_cnt;
   type_state        w_pout;
   logic [CNT_W-1:0] w_neff;

   assign w_neff = (nrounds_i > MaxR) ? MaxR : nrounds_i;

   p #(
      .CNT_W (CNT_W)
   ) u_p (
      .pin_i    (r_state),
      .roundp_i (r_cnt),
      .pout_o   (w_pout)
   );

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_fsm   <= StIdle;
         r_state <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_fsm)
            StIdle: begin
               if (start_i) begin
                  r_state <= state_i;
                  // Start late in the schedule so the final round is always index 11.
                  r_cnt   <= MaxR - w_neff;
                  r_fsm   <= (w_neff != '0) ? StRun : StDone;
               end
            end
            StRun: begin
               r_state <= w_pout;
               if (r_cnt == LastIdx) begin
                  r_fsm <= StDone;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StDone:  r_fsm <= StIdle;
            default: r_fsm <= StIdle;
         endcase
      end
   end

   assign state_o = r_state;
   assign round_o = r_cnt;
   assign busy_o  = (r_fsm != StIdle);
   assign done_o  = (r_fsm == StDone);

endmodule

// File: tb/tb_ascon_perm_seq.sv
// Directed bench for ascon_perm_seq; results checked against a table-driven round model.
module tb_ascon_perm_seq;
   import ascon_pack::*;

   logic       clock_i;
   logic       resetb_i;
   logic       start_i;
   logic [3:0] nrounds_i;
   type_state  state_i;
   type_state  state_o;
   logic       busy_o;
   logic       done_o;
   logic [3:0] round_o;

   int total = 0;
   int bad   = 0;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   ascon_perm_seq #(
      .MAX_ROUNDS (12),
      .CNT_W      (4)
   ) dut (
      .clock_i   (clock_i),
      .resetb_i  (resetb_i),
      .start_i   (start_i),
      .nrounds_i (nrounds_i),
      .state_i   (state_i),
      .state_o   (state_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .round_o   (round_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Reference round built on the S-box lookup table rather than the bitsliced form.
   function automatic type_state ref_round(input type_state s, input int r);
      logic [63:0] w [5];
      logic [63:0] o [5];
      logic [7:0]  c;
      logic [4:0]  idx;
      logic [4:0]  sv;
      type_state   res;
      c = 8'(((15 - r) << 4) | r);
      w[0] = s.x0; w[1] = s.x1; w[2] = s.x2 ^ {56'd0, c}; w[3] = s.x3; w[4] = s.x4;
      for (int b = 0; b < 64; b++) begin
         idx = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
         sv  = SBOX[idx];
         for (int i = 0; i < 5; i++) o[i][b] = sv[4-i];
      end
      res.x0 = o[0] ^ ror(o[0], 19) ^ ror(o[0], 28);
      res.x1 = o[1] ^ ror(o[1], 61) ^ ror(o[1], 39);
      res.x2 = o[2] ^ ror(o[2], 1)  ^ ror(o[2], 6);
      res.x3 = o[3] ^ ror(o[3], 10) ^ ror(o[3], 17);
      res.x4 = o[4] ^ ror(o[4], 7)  ^ ror(o[4], 41);
      return res;
   endfunction

   function automatic type_state ref_perm(input type_state s, input int neff);
      type_state t;
      t = s;
      for (int r = 12 - neff; r < 12; r++) t = ref_round(t, r);
      return t;
   endfunction

   // Runs one permutation, checking busy/done/round every cycle; optional stray start at cycle pulse_at.
   task automatic do_run(input type_state s, input logic [3:0] nr, input string tag,
                         input int pulse_at);
      int        neff;
      type_state exp;
      neff = (nr > 4'd12) ? 12 : int'(nr);
      exp  = ref_perm(s, neff);
      @(negedge clock_i);
      state_i   = s;
      nrounds_i = nr;
      start_i   = 1'b1;
      @(posedge clock_i); #1;
      start_i   = 1'b0;
      state_i   = ~s;
      nrounds_i = 4'd3;
      for (int n = 1; n <= neff + 1; n++) begin
         if (n > 1) begin
            @(posedge clock_i); #1;
         end
         if (n == pulse_at) begin
            start_i   = 1'b1;
            nrounds_i = 4'd0;
         end else begin
            start_i = 1'b0;
         end
         check({tag, "_busy"}, 320'(busy_o), 320'(1'b1));
         check({tag, "_done"}, 320'(done_o), 320'(n == neff + 1));
         if (n <= neff) check({tag, "_round"}, 320'(round_o), 320'(12 - neff + n - 1));
         else           check({tag, "_round_end"}, 320'(round_o), 320'((neff == 0) ? 12 : 11));
      end
      start_i = 1'b0;
      check({tag, "_state"}, state_o, exp);
      @(posedge clock_i); #1;
      check({tag, "_idle_busy"}, 320'(busy_o), 320'(1'b0));
      check({tag, "_idle_done"}, 320'(done_o), 320'(1'b0));
      check({tag, "_hold"}, state_o, exp);
   endtask

   type_state iv_st, pb_st;

   initial begin
      iv_st = '{64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                64'h0011223344556677, 64'h8899aabbccddeeff};
      pb_st = '{64'h598da474303d9164, 64'h7559456e06c73ad3, 64'h94beaba9335e44cd,
                64'h8866d2abc492c960, 64'hc11bf1d12e77b520};
      resetb_i  = 1'b0;
      start_i   = 1'b0;
      nrounds_i = 4'd0;
      state_i   = '0;

      repeat (2) @(posedge clock_i);
      #1;
      check("rst_state", state_o, '0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock_i); #1;
         check("idle_state", state_o, '0);
         check("idle_busy", 320'(busy_o), '0);
         check("idle_done", 320'(done_o), '0);
         check("idle_round", 320'(round_o), '0);
      end

      do_run(iv_st, 4'd12, "pa", -1);
      do_run(pb_st, 4'd6, "pb", -1);
      do_run(pb_st, 4'd0, "n0", -1);
      check("n0_pass", state_o, pb_st);
      do_run(iv_st, 4'd15, "n15", -1);
      do_run(pb_st, 4'd6, "busy_start", 3);
      // Immediately following: start lands in the IDLE cycle right after DONE.
      do_run(iv_st, 4'd6, "b2b", -1);

      @(negedge clock_i);
      state_i   = iv_st;
      nrounds_i = 4'd12;
      start_i   = 1'b1;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      for (int k = 0; k < 20 && round_o != 4'd5; k++) begin
         @(posedge clock_i); #1;
      end
      check("mid_round5", 320'(round_o), 320'(4'd5));
      #2;
      resetb_i = 1'b0;
      #1;
      check("mid_rst_state", state_o, '0);
      check("mid_rst_busy", 320'(busy_o), '0);
      check("mid_rst_done", 320'(done_o), '0);
      check("mid_rst_round", 320'(round_o), '0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock_i); #1;
         check("mid_rst_nodone", 320'(done_o), '0);
      end
      @(negedge clock_i);
      resetb_i = 1'b1;
      do_run(pb_st, 4'd6, "post_rst", -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no summary expected finish");
      $fatal(1);
   end

endmodule
